// File: rtl/iir_sos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_pkg
// Purpose  : Shared types, tap indices and helper functions for the
//            iir_sos_cascade_axis biquad cascade.
//            - state_t            : engine state encoding (IDLE, MAC, WB)
//            - TAP_B0..TAP_A2     : tap index within one section
//            - saturate()         : clamp a wide signed value to N bits
//            - passthrough_coeff(): coefficient value giving y = x
// Revision : 1.0  initial release
// ============================================================================
package iir_sos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int unsigned NUM_TAPS = 5;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    // Clamp to the signed range of a 'width'-bit word. Working width is
    // fixed at 64 bits so one helper serves every parameterisation.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] value,
        input int unsigned        width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // b0 = 1.0 in the coefficient Q-format, every other tap zero.
    function automatic logic signed [31:0] passthrough_coeff(
        input logic [2:0]  tap,
        input int unsigned scale
    );
        return (tap == TAP_B0) ? (32'sd1 <<< scale) : 32'sd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_sos_mac.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_mac
// Purpose  : Single signed multiplier feeding an add/subtract accumulator.
// Ports    : clk, rst_n      clock, async active-low reset
//            i_clear         zero the accumulator (has priority over i_en)
//            i_en            accumulate this cycle
//            i_sub           subtract the product instead of adding it
//            i_a, i_b        signed operands (sample, coefficient)
//            o_acc           signed accumulator, ACC_WIDTH bits
// Revision : 1.0  initial release
// ============================================================================
module iir_sos_mac #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic                        i_sub,
    input  logic signed [A_WIDTH-1:0]   i_a,
    input  logic signed [B_WIDTH-1:0]   i_b,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    localparam int unsigned PROD_W = A_WIDTH + B_WIDTH;

    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/iir_sos_cascade_axis.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_cascade_axis
// Purpose  : Cascade of NUM_SECTIONS DF1 biquads on one time-shared MAC,
//            AXI-Stream in/out, runtime-writable coefficients, saturating
//            output with sticky overflow flag, held output register.
// Ports    : s_axis_*    input sample stream (slave)
//            m_axis_*    filtered sample stream (master)
//            coeff_we/addr/data  coefficient write (addr = section*5 + tap)
//            coeff_ready high while IDLE; writes are ignored otherwise
//            overflow    sticky: some section clamped since reset
// Revision : 1.0  initial release
// ============================================================================
module iir_sos_cascade_axis
    import iir_sos_pkg::*;
#(
    parameter int unsigned INOUT_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH  = 16,
    parameter int unsigned SCALE_FACTOR = 14,
    parameter int unsigned NUM_SECTIONS = 4,
    parameter int unsigned ACC_WIDTH    = 40
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic signed [INOUT_WIDTH-1:0]           s_axis_tdata,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    output logic signed [INOUT_WIDTH-1:0]           m_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    input  logic                                    coeff_we,
    input  logic [$clog2(5*NUM_SECTIONS)-1:0]       coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]           coeff_data,
    output logic                                    coeff_ready,
    output logic                                    overflow
);

    localparam int unsigned NUM_COEFFS = NUM_TAPS * NUM_SECTIONS;
    localparam int unsigned ADDR_W     = $clog2(5 * NUM_SECTIONS);
    localparam int unsigned SEC_W      = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [SEC_W-1:0]              r_sec;
    logic [2:0]                    r_tap;

    logic signed [INOUT_WIDTH-1:0] r_x;
    logic signed [INOUT_WIDTH-1:0] r_x1 [NUM_SECTIONS];
    logic signed [INOUT_WIDTH-1:0] r_x2 [NUM_SECTIONS];
    logic signed [INOUT_WIDTH-1:0] r_y1 [NUM_SECTIONS];
    logic signed [INOUT_WIDTH-1:0] r_y2 [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] r_coeff [NUM_COEFFS];

    logic signed [INOUT_WIDTH-1:0] r_m_tdata;
    logic                          r_m_tvalid;
    logic                          r_overflow;

    logic                          w_accept;
    logic                          w_last_sec;
    logic                          w_last_tap;
    logic [ADDR_W-1:0]             w_cidx;
    logic signed [INOUT_WIDTH-1:0] w_operand;
    logic signed [COEFF_WIDTH-1:0] w_coeff;
    logic signed [ACC_WIDTH-1:0]   w_acc;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic signed [63:0]            w_wide;
    logic signed [63:0]            w_sat;
    logic signed [INOUT_WIDTH-1:0] w_y;
    logic                          w_clip;

    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_last_sec    = (r_sec == SEC_W'(NUM_SECTIONS - 1));
    assign w_last_tap    = (r_tap == TAP_A2);
    assign s_axis_tready = (r_state == IDLE) && (!r_m_tvalid || m_axis_tready);
    assign coeff_ready   = (r_state == IDLE);
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign overflow      = r_overflow;

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MAC;
            MAC:     if (w_last_tap) w_state_nxt = WB;
            WB:      w_state_nxt = w_last_sec ? IDLE : MAC;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec <= '0;
            r_tap <= TAP_B0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sec <= '0;
                    r_tap <= TAP_B0;
                end
                MAC: begin
                    if (!w_last_tap) r_tap <= r_tap + 3'd1;
                end
                WB: begin
                    r_tap <= TAP_B0;
                    r_sec <= w_last_sec ? '0 : r_sec + SEC_W'(1);
                end
                default: begin
                    r_sec <= '0;
                    r_tap <= TAP_B0;
                end
            endcase
        end
    end

    // ---------------- operand selection ----------------
    always_comb begin
        w_operand = r_x;
        case (r_tap)
            TAP_B1:  w_operand = r_x1[r_sec];
            TAP_B2:  w_operand = r_x2[r_sec];
            TAP_A1:  w_operand = r_y1[r_sec];
            TAP_A2:  w_operand = r_y2[r_sec];
            default: w_operand = r_x;
        endcase
        w_cidx  = ADDR_W'((32'(r_sec) * 32'd5) + 32'(r_tap));
        w_coeff = r_coeff[w_cidx];
    end

    iir_sos_mac #(
        .A_WIDTH   (INOUT_WIDTH),
        .B_WIDTH   (COEFF_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state == WB),
        .i_en    (r_state == MAC),
        .i_sub   (r_tap >= TAP_A1),
        .i_a     (w_operand),
        .i_b     (w_coeff),
        .o_acc   (w_acc)
    );

    // ---------------- scale and saturate section output ----------------
    always_comb begin
        w_shifted = w_acc >>> SCALE_FACTOR;
        w_wide    = {{(64 - ACC_WIDTH){w_shifted[ACC_WIDTH-1]}}, w_shifted};
        w_sat     = saturate(w_wide, INOUT_WIDTH);
        w_y       = w_sat[INOUT_WIDTH-1:0];
        w_clip    = (w_sat != w_wide);
    end

    // ---------------- sample and history registers ----------------
    // r_x holds the input of the section currently being computed; at each
    // WB it takes that section's output so the next section sees it as x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_x <= s_axis_tdata;
            end else if (r_state == WB) begin
                r_x         <= w_y;
                r_x2[r_sec] <= r_x1[r_sec];
                r_x1[r_sec] <= r_x;
                r_y2[r_sec] <= r_y1[r_sec];
                r_y1[r_sec] <= w_y;
            end
        end
    end

    // ---------------- coefficient register file ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                r_coeff[i] <= COEFF_WIDTH'(passthrough_coeff(3'(i % 5), SCALE_FACTOR));
            end
        end else if (coeff_we && (r_state == IDLE) && (32'(coeff_addr) < NUM_COEFFS)) begin
            r_coeff[coeff_addr] <= coeff_data;
        end
    end

    // ---------------- output register and overflow flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == WB && w_last_sec) begin
                r_m_tdata  <= w_y;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (r_state == WB && w_clip) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_cascade_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_sos_cascade_axis
// Purpose  : Scoreboard bench for iir_sos_cascade_axis. The driver pushes the
//            reference-model result for every accepted sample; an independent
//            monitor pops and compares at each output handshake and checks
//            latency, output hold, busy signalling and reset values.
// Revision : 1.0  initial release
// ============================================================================
module tb_iir_sos_cascade_axis;

    localparam int NS  = 4;
    localparam int SF  = 14;
    localparam int LAT = 6 * NS;

    typedef struct {
        int data;
        bit ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic signed [15:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               coeff_we;
    logic [4:0]         coeff_addr;
    logic signed [15:0] coeff_data;
    logic               coeff_ready;
    logic               overflow;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    mode   = 0;     // 0: m_tready high, 1: random, 2: held low
    bit    done_req = 1'b0;
    exp_t  exp_q[$];
    int    acc_q[$];

    // reference model state
    int     coef [NS][5];
    longint xh1 [NS], xh2 [NS], yh1 [NS], yh2 [NS];
    bit     model_ovf;

    iir_sos_cascade_axis #(
        .INOUT_WIDTH  (16),
        .COEFF_WIDTH  (16),
        .SCALE_FACTOR (SF),
        .NUM_SECTIONS (NS),
        .ACC_WIDTH    (40)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .coeff_we      (coeff_we),
        .coeff_addr    (coeff_addr),
        .coeff_data    (coeff_data),
        .coeff_ready   (coeff_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // downstream ready, changed away from both clock edges
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                1:       m_tready = 1'($urandom_range(0, 1));
                2:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int t = 0; t < 5; t++) coef[s][t] = (t == 0) ? (1 << SF) : 0;
            xh1[s] = 0; xh2[s] = 0; yh1[s] = 0; yh2[s] = 0;
        end
        model_ovf = 1'b0;
    endfunction

    function automatic int model_step(input int x_in);
        longint x, acc, y;
        x = x_in;
        for (int s = 0; s < NS; s++) begin
            acc = coef[s][0] * x + coef[s][1] * xh1[s] + coef[s][2] * xh2[s]
                - coef[s][3] * yh1[s] - coef[s][4] * yh2[s];
            y = acc >>> SF;
            if (y > 32767) begin
                y = 32767; model_ovf = 1'b1;
            end else if (y < -32768) begin
                y = -32768; model_ovf = 1'b1;
            end
            xh2[s] = xh1[s]; xh1[s] = x;
            yh2[s] = yh1[s]; yh1[s] = y;
            x = y;
        end
        return int'(x);
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push_expected(input int x);
        exp_t e;
        e.data = model_step(x);
        e.ovf  = model_ovf;
        exp_q.push_back(e);
    endtask

    task automatic send(input int x);
        int n;
        n = 0;
        s_tdata  = 16'(x);
        s_tvalid = 1'b1;
        while (!s_tready) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles, required 1", n);
                $fatal(1);
            end
        end
        push_expected(x);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    // sample and coefficient write presented on the same edge
    task automatic send_w(input int x, input int addr, input int data);
        s_tdata    = 16'(x);
        s_tvalid   = 1'b1;
        coeff_we   = 1'b1;
        coeff_addr = 5'(addr);
        coeff_data = 16'(data);
        if (!s_tready) begin
            $display("FAIL send_w_ready: s_axis_tready 0, required 1");
            $fatal(1);
        end
        coef[addr / 5][addr % 5] = data;
        push_expected(x);
        @(negedge clk);
        s_tvalid = 1'b0;
        coeff_we = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int data, input bit effective);
        coeff_we   = 1'b1;
        coeff_addr = 5'(addr);
        coeff_data = 16'(data);
        if (effective) coef[addr / 5][addr % 5] = data;
        @(negedge clk);
        coeff_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
                $fatal(1);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        coeff_we = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // passthrough after reset
        send(1000);
        send(-1000);
        wait_idle();

        // section 0 loaded with a low-pass biquad, impulse response
        do_reset();
        wcoef(0, 2962, 1); wcoef(1, 5615, 1); wcoef(2, 2962, 1);
        wcoef(3, -9362, 1); wcoef(4, 5203, 1);
        send(32767);
        for (int i = 0; i < 49; i++) send(0);
        wait_idle();

        // saturation and sticky overflow
        do_reset();
        wcoef(0, 32767, 1);
        send(32767);
        send(-32768);
        send(0);
        wait_idle();

        // long backpressure with continuous input
        mode = 2;
        fork
            begin
                for (int i = 0; i < 5; i++) send(i * 3000 - 7000);
            end
            begin
                repeat (200) @(negedge clk);
                mode = 0;
            end
        join
        wait_idle();

        // randomized samples, random ready, occasional coefficient writes
        mode = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                wait_idle();
                wcoef(int'($urandom_range(0, NS * 5 - 1)), int'($urandom_range(0, 32767)) - 16384, 1);
            end
            send(int'($urandom_range(0, 65535)) - 32768);
        end
        wait_idle();
        mode = 0;

        // coefficient write while busy is ignored, write in IDLE applies
        do_reset();
        send(1234);
        repeat (3) @(negedge clk);
        wcoef(0, 100, 0);
        send(2000);
        wait_idle();
        wcoef(0, 8192, 1);
        send(3000);
        wait_idle();
        send_w(4000, 5, 8192);
        wait_idle();

        // reset in the middle of a computation
        send(5555);
        repeat (4) @(negedge clk);
        do_reset();
        send(32767);
        send(0);
        send(0);
        wait_idle();

        repeat (3) @(negedge clk);
        done_req = 1'b1;
        repeat (10) @(negedge clk);
        $display("FAIL finish: monitor did not end the run");
        $fatal(1);
    end

    // ---------------- monitor / scoreboard ----------------
    bit               prev_valid = 1'b0;
    bit               prev_taken = 1'b0;
    logic signed [15:0] prev_data = '0;

    always @(negedge clk) begin
        bit   new_out;
        exp_t e;
        int   t;
        if (done_req) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (!rst_n) begin
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++; $display("FAIL reset_tvalid: got %b, required 0", m_tvalid);
            end
            checks++;
            if (m_tdata !== 16'sd0) begin
                errors++; $display("FAIL reset_tdata: got %0d, required 0", m_tdata);
            end
            checks++;
            if (overflow !== 1'b0) begin
                errors++; $display("FAIL reset_overflow: got %b, required 0", overflow);
            end
            checks++;
            if (s_tready !== 1'b1 || coeff_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready: s_tready %b coeff_ready %b, required 1 1", s_tready, coeff_ready);
            end
            acc_q.delete();
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            new_out = m_tvalid && (!prev_valid || prev_taken);

            // output must hold until taken
            if (prev_valid && !prev_taken) begin
                checks++;
                if (!(m_tvalid === 1'b1 && m_tdata === prev_data)) begin
                    errors++;
                    $display("FAIL hold: tvalid %b tdata %0d, required 1 %0d", m_tvalid, m_tdata, prev_data);
                end
            end
            if (m_tvalid && !m_tready) begin
                checks++;
                if (s_tready !== 1'b0) begin
                    errors++; $display("FAIL stall_tready: got %b, required 0", s_tready);
                end
            end

            // a sample is in flight: engine must be busy
            if (acc_q.size() != 0 && !new_out) begin
                checks++;
                if (coeff_ready !== 1'b0 || s_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy: coeff_ready %b s_tready %b, required 0 0", coeff_ready, s_tready);
                end
            end

            if (new_out) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++; $display("FAIL latency: output with no accepted sample, required none");
                end else begin
                    t = acc_q.pop_front();
                    if (cyc - t != LAT) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - t, LAT);
                    end
                end
            end

            if (s_tvalid && s_tready) acc_q.push_back(cyc + 1);

            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL data: unexpected output %0d, required none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(m_tdata) != e.data || overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL data: got %0d ovf %b, required %0d ovf %b",
                                 m_tdata, overflow, e.data, e.ovf);
                    end
                end
            end

            prev_valid = m_tvalid;
            prev_taken = m_tvalid && m_tready;
            prev_data  = m_tdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/iir_sos_cascade_axis.md
# iir_sos_cascade_axis

Parametrised cascade of NUM_SECTIONS Direct-Form-1 biquad sections behind AXI-Stream slave/master ports. It is the multi-section successor to the single-stage DF1 biquad: one time-multiplexed multiply-accumulate engine, coefficients writable at runtime, output saturation with a sticky flag, and a held output register so no result is lost under master backpressure. It sits in the sample path between an ADC/decimator stream source and a downstream AXIS consumer.

## Interface
- INOUT_WIDTH, 16, signed sample width on both streams
- COEFF_WIDTH, 16, signed coefficient width
- SCALE_FACTOR, 14, coefficient fractional bits (Q-format shift)
- NUM_SECTIONS, 4, biquad sections in cascade (1..8)
- ACC_WIDTH, 40, signed accumulator width (must be >= INOUT_WIDTH+COEFF_WIDTH+3)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- s_axis_tdata  in  INOUT_WIDTH  signed input sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  block can accept a sample
- m_axis_tdata  out  INOUT_WIDTH  signed filtered sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- coeff_we  in  1  coefficient write strobe
- coeff_addr  in  $clog2(5*NUM_SECTIONS)  section*5 + tap; taps 0..4 = b0,b1,b2,a1,a2
- coeff_data  in  COEFF_WIDTH  signed coefficient
- coeff_ready  out  1  high only in IDLE; writes with coeff_ready low are ignored
- overflow  out  1  sticky: any section output saturated since reset

## Operation
- Per section s: y = sat((b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> SCALE_FACTOR); arithmetic (floor) shift; y feeds section s+1 as x.
- Products full width INOUT_WIDTH+COEFF_WIDTH, sign-extended into ACC_WIDTH; a-terms subtracted.
- Saturation to [−2^(INOUT_WIDTH−1), 2^(INOUT_WIDTH−1)−1]; on clamp set overflow. Saturated value is stored as y1 history.
- States: IDLE -> MAC (5 cycles, taps 0..4 of current section) -> WB (1 cycle: history shift x2<=x1, x1<=x, y2<=y1, y1<=y; clear acc) -> MAC of next section, or, after last section, load output register and return to IDLE.
- s_axis_tready = (state==IDLE) && (!m_axis_tvalid || m_axis_tready).
- Output register holds tdata/tvalid stable until m_axis_tready; tvalid drops the cycle after handshake unless reloaded the same edge.
- Reset: state IDLE, all histories 0, acc 0, overflow 0, m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 1 after release, coefficients set to passthrough (b0 = 2^SCALE_FACTOR, others 0) in every section.
- Coefficient write: taking effect from the next accepted sample; history untouched.

## Timing
- Sample accepted at edge E0 (tvalid&&tready); m_axis_tvalid=1 after edge E0+6·NUM_SECTIONS (24 cycles default).
- Max throughput one sample per 6·NUM_SECTIONS+1 cycles when m_axis_tready held high.
- Same-edge consume and accept permitted (tready high, tvalid high in IDLE).
- m_axis_tready low at completion: engine waits in IDLE, s_axis_tready 0, no overwrite.
- rst_n low mid-MAC: immediate abort, outputs to reset values, partial sample discarded.
- coeff_we in same cycle as sample acceptance: write wins, sample uses new value.

## Structure
- Package iir_sos_pkg: state enum (IDLE, MAC, WB), tap index constants (TAP_B0..TAP_A2), saturate function, passthrough coefficient constant.
- Sub-module iir_sos_mac: single signed multiplier + accumulator with clear, add/subtract select, ACC_WIDTH result; top holds FSM, coefficient regfile, history regs, output register.

## Test plan
- After reset, no coeff writes, input 1000 then −1000 -> outputs 1000, −1000; each tvalid 24 cycles after acceptance.
- Section 0 loaded b0=2962,b1=5615,b2=2962,a1=−9362,a2=5203, others passthrough; impulse 32767 then zeros -> first two outputs 5923, 14614; matches bit-exact model for 50 samples.
- Section 0 b0=32767, input 32767 -> output 32767, overflow=1 and stays 1; input −32768 -> −32768.
- m_axis_tready low 200 cycles with continuous s_axis_tvalid -> tdata/tvalid stable, s_axis_tready 0, no sample dropped or duplicated on release.
- coeff_we while busy -> ignored (coeff_ready 0), read-back via output unchanged; write in IDLE -> effective next sample.
- rst_n pulsed low mid-MAC -> m_axis_tvalid 0 immediately, overflow 0, next impulse reproduces passthrough response.
